// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned DEPTH  = 128;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StCount,
    StData,
    StChk,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Little-endian byte-to-word packer: byte k of a word lands in bits [8k+7:8k].
module word_packer
  import imem_loader_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              last_byte,
  output logic              word_valid,
  output logic [N-1:0]      word
);

  localparam int unsigned Bytes = N / BYTE_W;
  localparam int unsigned CntW  = (Bytes > 1) ? $clog2(Bytes) : 1;

  logic [CntW-1:0]     cnt_q;
  // Earlier bytes of the current word, oldest at the bottom.
  logic [N-BYTE_W-1:0] shift_q;
  logic [N-1:0]        next_word;

  assign next_word = {byte_data, shift_q};
  assign last_byte = (cnt_q == CntW'(Bytes - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      shift_q    <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else if (clear) begin
      cnt_q      <= '0;
      shift_q    <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (byte_valid) begin
        shift_q <= next_word[N-1:BYTE_W];
        if (last_byte) begin
          word       <= next_word;
          word_valid <= 1'b1;
          cnt_q      <= '0;
        end else begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a count-prefixed byte stream into instruction RAM while holding the CPU in reset.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [N-1:0]      mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q, last_q;
  logic              in_ready_q, cpu_reset_q, busy_q, done_q, error_q;
  logic              accept, start_ok, data_byte, last_byte, final_byte, count_bad;

  assign accept     = in_valid && in_ready_q;
  assign start_ok   = start && (state_q inside {StIdle, StDone, StErr});
  assign data_byte  = accept && (state_q == StData);
  assign final_byte = data_byte && last_byte && (addr_q == last_q);
  assign count_bad  = (in_data == '0) || (32'(in_data) > DEPTH);

  word_packer #(
    .N(N)
  ) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_ok),
    .byte_valid(data_byte),
    .byte_data (in_data),
    .last_byte (last_byte),
    .word_valid(mem_we),
    .word      (mem_wdata)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] xor_q;

  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      xor_q <= '0;
    end else if (data_byte) begin
      xor_q <= xor_q ^ in_data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      last_q      <= '0;
      in_ready_q  <= 1'b0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      // Address advances after each write but parks on the last word.
      if (mem_we && (addr_q != last_q)) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
      unique case (state_q)
        StIdle, StDone, StErr: begin
          if (start_ok) begin
            state_q     <= StCount;
            addr_q      <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b1;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
          end else if (state_q == StDone) begin
            done_q      <= 1'b1;
            cpu_reset_q <= 1'b0;
          end
        end
        StCount: begin
          if (accept) begin
            if (count_bad) begin
              state_q    <= StErr;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              error_q    <= 1'b1;
            end else begin
              state_q <= StData;
              last_q  <= ADDR_W'(in_data - 8'd1);
            end
          end
        end
        StData: begin
          if (final_byte) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_q <= StChk;
`else
            state_q    <= StDone;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
`endif
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        StChk: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            if (in_data == xor_q) begin
              state_q     <= StDone;
              done_q      <= 1'b1;
              cpu_reset_q <= 1'b0;
            end else begin
              state_q <= StErr;
              error_q <= 1'b1;
            end
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_addr  = addr_q;
  assign cpu_reset = cpu_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
